cam_config: RTL and testbench

Configuration sequencer for the OV7670 bring-up path. It reads the camera register ROM entry by entry and hands each register address/data pair to the SCCB write master through a start/ready handshake. It also executes the in-ROM delay marker and stops at the end-of-ROM marker. It sits between the camera ROM and the SCCB master, and it raises a done flag that the capture path uses to hold off until the camera is configured.

---
 rtl/cam_pkg.sv | 39 +++
 rtl/cam_config.sv | 126 ++++++++++++
 tb/tb_cam_config.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 configuration path: ROM entry layout,
// marker encodings and the sequencer state enum.
package cam_pkg;

  localparam logic [15:0] CAM_ROM_END      = 16'hFF_FF;
  localparam logic [7:0]  CAM_ROM_DLY_ADDR = 8'hFF;
  localparam int          CAM_ROM_AW       = 8;

  typedef enum logic [3:0] {
    CAM_IDLE,
    CAM_FETCH,
    CAM_DECODE,
    CAM_SEND,
    CAM_ACK_GAP,
    CAM_WAIT_ACK,
    CAM_DELAY,
    CAM_NEXT,
    CAM_DONE
  } cam_state_e;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
  } cam_rom_entry_t;

  typedef enum logic [1:0] {
    CAM_ENT_WRITE,
    CAM_ENT_DELAY,
    CAM_ENT_END
  } cam_entry_e;

  // End marker takes priority over the delay marker (both share reg_addr FF).
  function automatic cam_entry_e cam_classify(input cam_rom_entry_t e);
    if (e == CAM_ROM_END)                 return CAM_ENT_END;
    else if (e.reg_addr == CAM_ROM_DLY_ADDR) return CAM_ENT_DELAY;
    else                                  return CAM_ENT_WRITE;
  endfunction

endpackage

// File: rtl/cam_config.sv
// Camera configuration sequencer: walks the register ROM, issues one SCCB
// write per entry, honours delay markers and stops at the end marker.
module cam_config
  import cam_pkg::*;
#(
  parameter int CLK_HZ       = 24_000_000,
  parameter int DELAY_MS     = 10,
  // Must be >= 1; a value of 1 yields a single-cycle DELAY state.
  parameter int DELAY_CYCLES = CLK_HZ / 1000 * DELAY_MS
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  output logic [CAM_ROM_AW-1:0] o_Rom_Addr,
  input  logic [15:0]           i_Rom_Data,
  output logic                  o_Sccb_Start,
  output logic [7:0]            o_Sccb_Addr,
  output logic [7:0]            o_Sccb_Data,
  input  logic                  i_Sccb_Ready,
  output logic                  o_Done
);

  localparam int                    CNT_W     = $clog2(DELAY_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CAM_ROM_AW-1:0] ADDR_LAST = '1;

  cam_state_e            state_q, state_d;
  logic [CAM_ROM_AW-1:0] addr_q, addr_d;
  logic [7:0]            sccb_addr_q, sccb_addr_d;
  logic [7:0]            sccb_data_q, sccb_data_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sccb_start;
  cam_rom_entry_t        rom_ent;

  assign rom_ent = cam_rom_entry_t'(i_Rom_Data);

  // Next-state and datapath updates; the start pulse is combinational on
  // ready so it can never fire while the master is busy.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sccb_addr_d = sccb_addr_q;
    sccb_data_d = sccb_data_q;
    done_d      = done_q;
    cnt_d       = cnt_q;
    sccb_start  = 1'b0;
    unique case (state_q)
      CAM_IDLE, CAM_DONE: begin
        if (i_Start) begin
          state_d = CAM_FETCH;
          addr_d  = '0;
          done_d  = 1'b0;
        end
      end
      CAM_FETCH: state_d = CAM_DECODE;
      CAM_DECODE: begin
        unique case (cam_classify(rom_ent))
          CAM_ENT_END: begin
            state_d = CAM_DONE;
            done_d  = 1'b1;
          end
          CAM_ENT_DELAY: begin
            state_d = CAM_DELAY;
            cnt_d   = CNT_LOAD;
          end
          default: begin
            state_d     = CAM_SEND;
            sccb_addr_d = rom_ent.reg_addr;
            sccb_data_d = rom_ent.reg_data;
          end
        endcase
      end
      CAM_SEND: begin
        if (i_Sccb_Ready) begin
          sccb_start = 1'b1;
          state_d    = CAM_ACK_GAP;
        end
      end
      // Master drops ready only the cycle after accepting; skip that cycle.
      CAM_ACK_GAP: state_d = CAM_WAIT_ACK;
      CAM_WAIT_ACK: if (i_Sccb_Ready) state_d = CAM_NEXT;
      CAM_DELAY: begin
        if (cnt_q == '0) state_d = CAM_NEXT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      CAM_NEXT: begin
        // Address never wraps: the last entry always terminates the run.
        if (addr_q == ADDR_LAST) begin
          state_d = CAM_DONE;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = CAM_FETCH;
        end
      end
      default: state_d = CAM_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_q     <= CAM_IDLE;
      addr_q      <= '0;
      sccb_addr_q <= '0;
      sccb_data_q <= '0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sccb_addr_q <= sccb_addr_d;
      sccb_data_q <= sccb_data_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_Rom_Addr   = addr_q;
  assign o_Sccb_Start = sccb_start;
  assign o_Sccb_Addr  = sccb_addr_q;
  assign o_Sccb_Data  = sccb_data_q;
  assign o_Done       = done_q;

endmodule

// File: tb/tb_cam_config.sv
// Bench for cam_config: registered ROM model, SCCB master model with a
// programmable busy time, and a write scoreboard checked on every start.
module tb_cam_config;
  import cam_pkg::*;

  localparam int DLY = 20;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b0;
  logic        i_Start = 1'b0;
  logic [7:0]  o_Rom_Addr;
  logic [15:0] i_Rom_Data = '0;
  logic        o_Sccb_Start;
  logic [7:0]  o_Sccb_Addr;
  logic [7:0]  o_Sccb_Data;
  logic        i_Sccb_Ready;
  logic        o_Done;

  cam_config #(.DELAY_CYCLES(DLY)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start),
    .o_Rom_Addr(o_Rom_Addr), .i_Rom_Data(i_Rom_Data),
    .o_Sccb_Start(o_Sccb_Start), .o_Sccb_Addr(o_Sccb_Addr),
    .o_Sccb_Data(o_Sccb_Data), .i_Sccb_Ready(i_Sccb_Ready), .o_Done(o_Done)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Cycle counter and ROM model (data one clock after address).
  int cyc = 0;
  logic [15:0] rom [256];
  always @(posedge i_Clk) begin
    cyc        <= cyc + 1;
    i_Rom_Data <= rom[o_Rom_Addr];
  end

  // Scoreboard and monitor state.
  logic [15:0] exp_q[$];
  int          start_cyc_q[$];
  int          rise_cyc_q[$];
  int          n_starts = 0;
  logic        start_seen = 1'b0;
  logic        prev_start = 1'b0;
  logic        pend = 1'b0;
  logic [15:0] pend_ent = '0;

  always @(negedge i_Clk) begin
    logic [15:0] e;
    if (!i_Rst) pend = 1'b0;
    else if (pend) begin
      chk("sccb_hold", {16'h0, o_Sccb_Addr, o_Sccb_Data}, {16'h0, pend_ent});
      if (i_Sccb_Ready) begin
        pend = 1'b0;
        rise_cyc_q.push_back(cyc);
      end
    end
    if (o_Sccb_Start) begin
      chk("start_rdy", i_Sccb_Ready, 1);
      chk("start_b2b", prev_start, 0);
      n_starts++;
      start_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("sb_extra", {o_Sccb_Addr, o_Sccb_Data}, 32'hDEAD);
      else begin
        e = exp_q.pop_front();
        chk("sb_write", {o_Sccb_Addr, o_Sccb_Data}, e);
      end
      pend     = 1'b1;
      pend_ent = {o_Sccb_Addr, o_Sccb_Data};
    end
    prev_start = o_Sccb_Start;
    start_seen = o_Sccb_Start;
  end

  // SCCB master model: ready drops the cycle after an accepted start.
  int   busy_len = 30;
  int   busy_cnt = 0;
  logic hold_low = 1'b0;
  initial begin
    i_Sccb_Ready = 1'b1;
    forever begin
      @(posedge i_Clk);
      #1;
      if (start_seen)        busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      i_Sccb_Ready = (busy_cnt == 0) && !hold_low;
    end
  end

  task automatic pulse_start(output int t0);
    @(posedge i_Clk); #1;
    i_Start = 1'b1;
    t0 = cyc;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    do begin
      @(negedge i_Clk);
      n++;
    end while (!o_Done && n < bound);
    chk("done_tmo", o_Done, 1);
  endtask

  task automatic load_rom_a();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
  endtask

  task automatic load_rom_b();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h3A04;
  endtask

  initial begin
    int t0, base, gap, n;
    load_rom_a();

    // Reset state.
    repeat (3) @(posedge i_Clk);
    #1 i_Rst = 1'b1;
    @(negedge i_Clk);
    chk("rst_addr", o_Rom_Addr, 0);
    chk("rst_sa", o_Sccb_Addr, 0);
    chk("rst_sd", o_Sccb_Data, 0);
    chk("rst_start", o_Sccb_Start, 0);
    chk("rst_done", o_Done, 0);
    repeat (10) @(negedge i_Clk);
    chk("idle_nostart", n_starts, 0);

    // Main sequence: two writes around a delay marker.
    start_cyc_q.delete(); rise_cyc_q.delete();
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1204);
    base = n_starts;
    pulse_start(t0);
    wait_done(2000);
    chk("a_done_addr", o_Rom_Addr, 3);
    chk("a_nwrites", n_starts - base, 2);
    chk("a_sb_empty", exp_q.size(), 0);
    if (start_cyc_q.size() >= 2 && rise_cyc_q.size() >= 1) begin
      chk("a_latency", start_cyc_q[0] - t0, 3);
      gap = start_cyc_q[1] - rise_cyc_q[0];
      chk("a_gap_ge20", gap >= 20, 1);
      chk("a_gap", gap, DLY + 7);
    end else chk("a_events", start_cyc_q.size(), 2);
    repeat (5) @(negedge i_Clk);
    chk("a_done_hold", o_Done, 1);

    // Start mid-sequence is ignored; start in DONE re-runs.
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1204);
    base = n_starts;
    pulse_start(t0);
    n = 0;
    while (o_Rom_Addr != 8'd1 && n < 500) begin @(negedge i_Clk); n++; end
    chk("m_reach1", o_Rom_Addr, 1);
    pulse_start(t0);
    wait_done(2000);
    chk("m_done_addr", o_Rom_Addr, 3);
    chk("m_nwrites", n_starts - base, 2);
    chk("m_sb_empty", exp_q.size(), 0);
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1204);
    pulse_start(t0);
    chk("r_done_drop", o_Done, 0);
    chk("r_addr0", o_Rom_Addr, 0);
    wait_done(2000);
    chk("r_sb_empty", exp_q.size(), 0);

    // Ready held low while the write waits in SEND.
    load_rom_b();
    hold_low = 1'b1;
    repeat (2) @(negedge i_Clk);
    exp_q.push_back(16'h3A04);
    base = n_starts;
    pulse_start(t0);
    repeat (3) @(negedge i_Clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge i_Clk);
      chk("h_hold", {o_Sccb_Addr, o_Sccb_Data}, 16'h3A04);
    end
    chk("h_nostart", n_starts - base, 0);
    hold_low = 1'b0;
    @(negedge i_Clk);
    chk("h_rdy_rise", i_Sccb_Ready, 1);
    chk("h_pulse", o_Sccb_Start, 1);
    @(negedge i_Clk);
    chk("h_pulse_end", o_Sccb_Start, 0);
    wait_done(2000);
    chk("h_nwrites", n_starts - base, 1);

    // Reset during WAIT_ACK abandons the transfer.
    exp_q.push_back(16'h3A04);
    base = n_starts;
    pulse_start(t0);
    n = 0;
    while (n_starts == base && n < 100) begin @(negedge i_Clk); n++; end
    chk("w_started", n_starts - base, 1);
    repeat (3) @(negedge i_Clk);
    @(posedge i_Clk); #1 i_Rst = 1'b0;
    @(posedge i_Clk); #1 i_Rst = 1'b1;
    chk("w_addr", o_Rom_Addr, 0);
    chk("w_sa", o_Sccb_Addr, 0);
    chk("w_sd", o_Sccb_Data, 0);
    chk("w_start", o_Sccb_Start, 0);
    chk("w_done", o_Done, 0);
    base = n_starts;
    repeat (60) @(negedge i_Clk);
    chk("w_idle", n_starts - base, 0);
    chk("w_idle_done", o_Done, 0);
    exp_q.push_back(16'h3A04);
    pulse_start(t0);
    wait_done(2000);
    chk("w_nwrites", n_starts - base, 1);
    chk("w_sb_empty", exp_q.size(), 0);

    // No end marker: all 256 entries written, stop at the last address.
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'h3A04;
      exp_q.push_back(16'h3A04);
    end
    busy_len = 2;
    base = n_starts;
    pulse_start(t0);
    wait_done(20000);
    chk("f_done_addr", o_Rom_Addr, 255);
    chk("f_nwrites", n_starts - base, 256);
    chk("f_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
